bank_access_ctrl: RTL and testbench
===================================

Name: bank_access_ctrl

Overview:
- Access controller that drives one 64-bit x 1024-entry data bank's read and write ports.
- Write side: round-robin arbitration among three write clients (interconnect i, DMA d, compute c). Produces the bank's wr_en, wr_addr and wr_muxcode, plus one-hot grants back to the clients.
- Read side: burst sequencer. Issues rd_en/rd_addr for a base/length burst and emits rd_valid aligned to bank read data.
- Sits between client logic and the bank; one instance per bank.

Parameters:
- a, 10, bank address width (depth 2^a words).
- LAT, 1, bank read latency in cycles from rd_en to valid read data (1..4).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wri_req  in  1  interconnect client write request.
- wri_addr  in  a  interconnect client write address.
- wrd_req  in  1  DMA client write request.
- wrd_addr  in  a  DMA client write address.
- wrc_req  in  1  compute client write request.
- wrc_addr  in  a  compute client write address.
- wr_gnt  out  3  one-hot grant: bit0=i, bit1=d, bit2=c; client presents data in the same cycle.
- wr_en  out  1  bank write enable.
- wr_addr  out  a  bank write address.
- wr_muxcode  out  2  bank write source select: 00=i, 01=d, 10=c.
- rd_start  in  1  start read burst (accepted only when rd_busy=0).
- rd_base  in  a  burst start address.
- rd_len  in  a+1  burst length in words, 0..2^a.
- rd_stall  in  1  hold burst; no rd_en issued while high.
- rd_busy  out  1  burst in progress (BURST or DRAIN).
- rd_en  out  1  bank read enable.
- rd_addr  out  a  bank read address.
- rd_valid  out  1  bank read data valid this cycle.
- rd_done  out  1  one-cycle pulse coincident with the last rd_valid of a burst.

Behaviour:
- Reset: all outputs 0; wr_muxcode=00; RR pointer=i; FSM=IDLE; valid pipe cleared.
- Reset mid-burst: burst abandoned with no rd_done pulse. rd_valid is 0 from the cycle after rst.
- Write arbiter grant: combinational from the current *_req and the registered RR pointer.
- Write arbiter priority: search starts at the pointer, in order i->d->c->i.
- Write arbiter outputs:
  - wr_en = |wr_gnt.
  - wr_addr = granted client's address.
  - wr_muxcode = granted index.
  - With no grant: wr_en=0, wr_addr=0, wr_muxcode=00. Code 11 is never driven.
- RR pointer: on a grant it advances to (granted index + 1) mod 3; otherwise it holds.
- Write arbitration is independent of read state. One write per cycle maximum.
- Read FSM, IDLE:
  - rd_start with rd_len>0: load addr=rd_base, remaining=rd_len, go to BURST.
  - rd_len=0: ignored; no busy, no done.
  - rd_start while busy: ignored.
- Read FSM, BURST:
  - Each cycle with rd_stall=0: rd_en=1, rd_addr=addr, addr+=1 (wraps mod 2^a), remaining-=1.
  - After the last issue, go to DRAIN.
  - With rd_stall=1: rd_en=0; addr and remaining hold.
- Read FSM, DRAIN: wait until the valid pipe is empty, then go to IDLE. rd_busy deasserts the cycle after rd_done.
- rd_en/rd_addr are registered outputs: first rd_en appears 1 cycle after rd_start is accepted.
- rd_valid = rd_en delayed exactly LAT cycles via shift register. rd_done = rd_valid AND last-word tag carried down the same pipe.
- Read/write to the same address in the same cycle is passed through unchecked by default; bank returns undefined data.

Optional Feature:
- Macro: BANK_ACCESS_CTRL_COLL_STALL_EN.
- Defined: in BURST, if wr_en=1 and the granted wr_addr equals the address about to issue, the read issue is suppressed for that cycle (acts as an internal rd_stall). Write priority is kept; the burst length is unchanged.
- Not defined: no address compare; collision logic absent.

Test Plan:
- Reset, then wri_req=wrd_req=wrc_req=1 held for 6 cycles, addrs 5/6/7 -> wr_gnt sequence 001,010,100,001,010,100; wr_muxcode 00,01,10,...; wr_addr 5,6,7,...
- Only wrd_req=1, addr 0x3FF, 3 cycles -> wr_gnt=010 every cycle, wr_en=1, wr_muxcode=01, wr_addr=0x3FF.
- rd_base=0x3FE, rd_len=4, LAT=1 -> rd_addr 0x3FE,0x3FF,0x000,0x001 on consecutive cycles; rd_valid 1 cycle later; rd_done with 4th valid; rd_busy low the next cycle.
- rd_len=3 with rd_stall=1 on the 2nd issue cycle -> rd_en pattern 1,0,1,1; addresses base, base+1, base+2; exactly 3 rd_valid; one rd_done.
- rst asserted during a rd_len=8 burst after 3 issues -> rd_en/rd_valid/rd_busy 0 the next cycle; no rd_done; new rd_start accepted immediately after rst deasserts.
- With BANK_ACCESS_CTRL_COLL_STALL_EN defined: burst at base 0x010 with wri write to 0x010 in the first issue cycle -> rd_en 0 that cycle, read of 0x010 issued the next cycle and returns the written data.

Source files
------------

// File: rtl/bank_access_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : bank_access_ctrl                                             |
// | Description : Access controller for one data bank (64-bit x 2^a words).    |
// |               Write side: round-robin arbiter over three write clients     |
// |               (interconnect i, DMA d, compute c) driving the bank write    |
// |               port.                                                        |
// |               Read side: base/length burst sequencer driving the bank read |
// |               port, with a LAT-deep valid pipe aligned to read data.       |
// | Option      : define BANK_ACCESS_CTRL_COLL_STALL_EN to hold a read issue   |
// |               for one cycle when it targets the address being written in   |
// |               that same cycle.                                             |
// | Ports       : clk, rst                 clock, sync active-high reset       |
// |               wr{i,d,c}_req/_addr      write client requests/addresses     |
// |               wr_gnt                   one-hot grant {c,d,i}               |
// |               wr_en/wr_addr/wr_muxcode bank write port controls            |
// |               rd_start/rd_base/rd_len  burst request                       |
// |               rd_stall                 hold burst issue                    |
// |               rd_busy                  burst in progress                   |
// |               rd_en/rd_addr            bank read port controls             |
// |               rd_valid/rd_done         read data valid / last word         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module bank_access_ctrl #(
   parameter int a   = 10,  // bank address width
   parameter int LAT = 1    // bank read latency, 1..4
) (
   input  logic         clk,
   input  logic         rst,
   // write clients
   input  logic         wri_req,
   input  logic [a-1:0] wri_addr,
   input  logic         wrd_req,
   input  logic [a-1:0] wrd_addr,
   input  logic         wrc_req,
   input  logic [a-1:0] wrc_addr,
   output logic [2:0]   wr_gnt,
   output logic         wr_en,
   output logic [a-1:0] wr_addr,
   output logic [1:0]   wr_muxcode,
   // read burst
   input  logic         rd_start,
   input  logic [a-1:0] rd_base,
   input  logic [a:0]   rd_len,
   input  logic         rd_stall,
   output logic         rd_busy,
   output logic         rd_en,
   output logic [a-1:0] rd_addr,
   output logic         rd_valid,
   output logic         rd_done
);

   localparam logic [a-1:0] c_ADDR_ONE = 1;
   localparam logic [a:0]   c_LEN_ONE  = 1;

   // Round-robin pointer encoding: index of the client searched first.
   localparam logic [1:0] c_IDX_I = 2'd0;
   localparam logic [1:0] c_IDX_D = 2'd1;
   localparam logic [1:0] c_IDX_C = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

   // ------------------------------------------------------------------------
   // Write arbiter
   // ------------------------------------------------------------------------
   logic [1:0]   rr_ptr_q, rr_ptr_d;
   logic [2:0]   w_gnt;
   logic         w_wr_en;
   logic [a-1:0] w_wr_addr;
   logic [1:0]   w_wr_mux;

   always_comb begin
      w_gnt = 3'b000;
      case (rr_ptr_q)
         c_IDX_D: begin
            if      (wrd_req) w_gnt = 3'b010;
            else if (wrc_req) w_gnt = 3'b100;
            else if (wri_req) w_gnt = 3'b001;
         end
         c_IDX_C: begin
            if      (wrc_req) w_gnt = 3'b100;
            else if (wri_req) w_gnt = 3'b001;
            else if (wrd_req) w_gnt = 3'b010;
         end
         default: begin
            if      (wri_req) w_gnt = 3'b001;
            else if (wrd_req) w_gnt = 3'b010;
            else if (wrc_req) w_gnt = 3'b100;
         end
      endcase
   end

   // Address/source mux and pointer advance; the pointer moves to the client
   // after the winner so a continuously requesting client cannot starve others.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      w_wr_addr = '0;
      w_wr_mux  = 2'b00;
      if (w_gnt[0]) begin
         w_wr_addr = wri_addr;
         w_wr_mux  = c_IDX_I;
         rr_ptr_d  = c_IDX_D;
      end else if (w_gnt[1]) begin
         w_wr_addr = wrd_addr;
         w_wr_mux  = c_IDX_D;
         rr_ptr_d  = c_IDX_C;
      end else if (w_gnt[2]) begin
         w_wr_addr = wrc_addr;
         w_wr_mux  = c_IDX_C;
         rr_ptr_d  = c_IDX_I;
      end
   end

   assign w_wr_en    = |w_gnt;
   assign wr_gnt     = w_gnt;
   assign wr_en      = w_wr_en;
   assign wr_addr    = w_wr_addr;
   assign wr_muxcode = w_wr_mux;

   // ------------------------------------------------------------------------
   // Read burst sequencer
   // ------------------------------------------------------------------------
   rd_state_t    state_q, state_d;
   logic [a-1:0] addr_q, addr_d;    // next address to issue
   logic [a:0]   rem_q, rem_d;      // words still to issue
   logic [LAT-1:0] vpipe_q, vpipe_d;  // rd_en delay line
   logic [LAT-1:0] lpipe_q, lpipe_d;  // last-word tag delay line
   logic [LAT-1:0] w_vpipe_shift;
   logic         w_issue;
   logic         w_last;
   logic         w_coll;

`ifdef BANK_ACCESS_CTRL_COLL_STALL_EN
   // A write to the word about to be read wins this cycle; the read goes out
   // one cycle later and therefore sees the freshly written data.
   assign w_coll = w_wr_en && (w_wr_addr == addr_q);
`else
   assign w_coll = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      w_issue = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Zero-length requests are dropped without raising busy.
            if (rd_start && (rd_len != '0)) begin
               addr_d  = rd_base;
               rem_d   = rd_len;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (!rd_stall && !w_coll) begin
               w_issue = 1'b1;
               addr_d  = addr_q + c_ADDR_ONE;
               rem_d   = rem_q - c_LEN_ONE;
               if (rem_q == c_LEN_ONE) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Leave once only the output stage can still hold a valid, so
            // busy drops the cycle after the final rd_valid/rd_done.
            if (w_vpipe_shift == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign w_last        = w_issue && (rem_q == c_LEN_ONE);
   assign w_vpipe_shift = vpipe_q << 1;
   assign vpipe_d       = w_vpipe_shift | LAT'(w_issue);
   assign lpipe_d       = (lpipe_q << 1) | LAT'(w_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= c_IDX_I;
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         vpipe_q  <= '0;
         lpipe_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         vpipe_q  <= vpipe_d;
         lpipe_q  <= lpipe_d;
      end
   end

   // rd_en/rd_addr come straight from the burst registers, gated only by the
   // stall conditions, so the first issue lands the cycle after acceptance.
   assign rd_en    = w_issue;
   assign rd_addr  = w_issue ? addr_q : '0;
   assign rd_busy  = (state_q != ST_IDLE);
   assign rd_valid = vpipe_q[LAT-1];
   assign rd_done  = vpipe_q[LAT-1] & lpipe_q[LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_bank_access_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_bank_access_ctrl                                          |
// | Description : Self-checking bench for bank_access_ctrl (a=10, LAT=1).      |
// |               Stimulus pushes expected write grants, read addresses and    |
// |               done flags into queues; a negedge monitor pops and compares  |
// |               whenever the DUT asserts wr_en, rd_en or rd_valid.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bank_access_ctrl;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          wri_req, wrd_req, wrc_req;
   logic [AW-1:0] wri_addr, wrd_addr, wrc_addr;
   logic [2:0]    wr_gnt;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [1:0]    wr_muxcode;
   logic          rd_start;
   logic [AW-1:0] rd_base;
   logic [AW:0]   rd_len;
   logic          rd_stall;
   logic          rd_busy, rd_en, rd_valid, rd_done;
   logic [AW-1:0] rd_addr;

   bank_access_ctrl #(.a(AW), .LAT(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .wri_req    (wri_req),
      .wri_addr   (wri_addr),
      .wrd_req    (wrd_req),
      .wrd_addr   (wrd_addr),
      .wrc_req    (wrc_req),
      .wrc_addr   (wrc_addr),
      .wr_gnt     (wr_gnt),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_muxcode (wr_muxcode),
      .rd_start   (rd_start),
      .rd_base    (rd_base),
      .rd_len     (rd_len),
      .rd_stall   (rd_stall),
      .rd_busy    (rd_busy),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_valid   (rd_valid),
      .rd_done    (rd_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]    gnt;
      logic [AW-1:0] addr;
      logic [1:0]    mux;
   } wr_exp_t;

   wr_exp_t       wr_q[$];
   logic [AW-1:0] rd_q[$];
   logic          vl_q[$];

   int   checks = 0;
   int   errors = 0;
   logic mon_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (mon_on) begin
         if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_unexpected: got wr_gnt %b addr %0h with no write expected", wr_gnt, wr_addr);
            end else begin
               wr_exp_t e;
               e = wr_q.pop_front();
               chk("wr_gnt", {29'd0, wr_gnt}, {29'd0, e.gnt});
               chk("wr_addr", {22'd0, wr_addr}, {22'd0, e.addr});
               chk("wr_muxcode", {30'd0, wr_muxcode}, {30'd0, e.mux});
            end
         end
         if (rd_en === 1'b1) begin
            if (rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected: got rd_en at addr %0h with no read expected", rd_addr);
            end else begin
               logic [AW-1:0] ea;
               ea = rd_q.pop_front();
               chk("rd_addr", {22'd0, rd_addr}, {22'd0, ea});
            end
         end
         if (rd_valid === 1'b1) begin
            if (vl_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_valid_unexpected: got rd_valid=1 required 0");
            end else begin
               logic ed;
               ed = vl_q.pop_front();
               chk("rd_done", {31'd0, rd_done}, {31'd0, ed});
            end
         end else if (rd_done === 1'b1) begin
            checks++; errors++;
            $display("FAIL rd_done_no_valid: got rd_done=1 with rd_valid=0 required 0");
         end
      end
   end

   // Runs n cycles of read stimulus; per-cycle masks drive start/stall/reset.
   // Bit k of each returned vector is the output sampled in cycle k.
   task automatic burst(input logic [AW-1:0] base, input logic [AW:0] len,
                        input logic [15:0] start_m, input logic [15:0] stall_m,
                        input logic [15:0] rst_m, input int n,
                        output logic [15:0] en, output logic [15:0] vl,
                        output logic [15:0] dn, output logic [15:0] bz);
      en = '0; vl = '0; dn = '0; bz = '0;
      for (int k = 0; k < n; k++) begin
         rd_base  = base;
         rd_len   = len;
         rd_start = (k < 16) ? start_m[k[3:0]] : 1'b0;
         rd_stall = (k < 16) ? stall_m[k[3:0]] : 1'b0;
         rst      = (k < 16) ? rst_m[k[3:0]]   : 1'b0;
         @(negedge clk);
         if (k < 16) begin
            en[k[3:0]] = rd_en;
            vl[k[3:0]] = rd_valid;
            dn[k[3:0]] = rd_done;
            bz[k[3:0]] = rd_busy;
         end
         tick();
      end
      rd_start = 1'b0;
      rd_stall = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic chk_burst(input string name, input logic [15:0] en, input logic [15:0] vl,
                            input logic [15:0] dn, input logic [15:0] bz,
                            input logic [15:0] xen, input logic [15:0] xvl,
                            input logic [15:0] xdn, input logic [15:0] xbz);
      chk({name, "_rd_en"},    {16'd0, en}, {16'd0, xen});
      chk({name, "_rd_valid"}, {16'd0, vl}, {16'd0, xvl});
      chk({name, "_rd_done"},  {16'd0, dn}, {16'd0, xdn});
      chk({name, "_rd_busy"},  {16'd0, bz}, {16'd0, xbz});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] en, vl, dn, bz;

      rst = 1'b1;
      wri_req = 0; wrd_req = 0; wrc_req = 0;
      wri_addr = '0; wrd_addr = '0; wrc_addr = '0;
      rd_start = 0; rd_base = '0; rd_len = '0; rd_stall = 0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state: every output low.
      @(negedge clk);
      chk("reset_outputs",
          {8'd0, wr_gnt, wr_en, wr_addr, wr_muxcode, rd_busy, rd_en, rd_addr, rd_valid, rd_done},
          32'd0);
      tick();
      rst    = 1'b0;
      mon_on = 1'b1;

      // All three clients requesting: strict rotation i,d,c.
      wri_req = 1; wri_addr = 10'd5;
      wrd_req = 1; wrd_addr = 10'd6;
      wrc_req = 1; wrc_addr = 10'd7;
      for (int r = 0; r < 2; r++) begin
         wr_q.push_back({3'b001, 10'd5, 2'b00});
         wr_q.push_back({3'b010, 10'd6, 2'b01});
         wr_q.push_back({3'b100, 10'd7, 2'b10});
      end
      repeat (6) tick();
      wri_req = 0; wrd_req = 0; wrc_req = 0;

      // No requests: idle write port.
      @(negedge clk);
      chk("wr_idle", {17'd0, wr_gnt, wr_en, wr_addr, wr_muxcode}, 32'd0);
      tick();

      // DMA alone at the top address keeps winning.
      wrd_req = 1; wrd_addr = 10'h3FF;
      repeat (3) wr_q.push_back({3'b010, 10'h3FF, 2'b01});
      repeat (3) tick();
      wrd_req = 0;

      // Pointer now at c; with i and d requesting, the search wraps to i.
      wri_req = 1; wri_addr = 10'h011;
      wrd_req = 1; wrd_addr = 10'h022;
      wr_q.push_back({3'b001, 10'h011, 2'b00});
      wr_q.push_back({3'b010, 10'h022, 2'b01});
      wr_q.push_back({3'b001, 10'h011, 2'b00});
      repeat (3) tick();
      wri_req = 0; wrd_req = 0;
      tick();

      // Burst wrapping past the top of the address space.
      rd_q.push_back(10'h3FE); rd_q.push_back(10'h3FF);
      rd_q.push_back(10'h000); rd_q.push_back(10'h001);
      vl_q.push_back(0); vl_q.push_back(0); vl_q.push_back(0); vl_q.push_back(1);
      burst(10'h3FE, 11'd4, 16'h0001, 16'h0000, 16'h0000, 7, en, vl, dn, bz);
      chk_burst("wrap", en, vl, dn, bz, 16'h001E, 16'h003C, 16'h0020, 16'h003E);

      // Stall on the second issue cycle.
      rd_q.push_back(10'h100); rd_q.push_back(10'h101); rd_q.push_back(10'h102);
      vl_q.push_back(0); vl_q.push_back(0); vl_q.push_back(1);
      burst(10'h100, 11'd3, 16'h0001, 16'h0004, 16'h0000, 7, en, vl, dn, bz);
      chk_burst("stall", en, vl, dn, bz, 16'h001A, 16'h0034, 16'h0020, 16'h003E);

      // Zero-length request is ignored.
      burst(10'h123, 11'd0, 16'h0001, 16'h0000, 16'h0000, 3, en, vl, dn, bz);
      chk_burst("len0", en, vl, dn, bz, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

      // A second start while busy is ignored.
      rd_q.push_back(10'h300); rd_q.push_back(10'h301);
      vl_q.push_back(0); vl_q.push_back(1);
      burst(10'h300, 11'd2, 16'h0003, 16'h0000, 16'h0000, 5, en, vl, dn, bz);
      chk_burst("busy_start", en, vl, dn, bz, 16'h0006, 16'h000C, 16'h0008, 16'h000E);

      // Maximum length: every word of the bank.
      for (int i = 0; i < 1024; i++) begin
         rd_q.push_back(i[AW-1:0]);
         vl_q.push_back(i == 1023);
      end
      burst(10'h000, 11'h400, 16'h0001, 16'h0000, 16'h0000, 1027, en, vl, dn, bz);
      chk("full_len_first_en", {16'd0, en}, 32'h0000_FFFE);
      @(negedge clk);
      chk("full_len_busy_end", {31'd0, rd_busy}, 32'd0);
      tick();

      // Reset after three issues of an 8-word burst, then restart at once.
      rd_q.push_back(10'h200); rd_q.push_back(10'h201); rd_q.push_back(10'h202);
      vl_q.push_back(0); vl_q.push_back(0);
      burst(10'h200, 11'd8, 16'h0001, 16'h0000, 16'h0008, 4, en, vl, dn, bz);
      chk_burst("pre_rst", en, vl, dn, bz, 16'h000E, 16'h000C, 16'h0000, 16'h000E);
      rd_q.push_back(10'h050); rd_q.push_back(10'h051);
      vl_q.push_back(0); vl_q.push_back(1);
      burst(10'h050, 11'd2, 16'h0001, 16'h0000, 16'h0000, 5, en, vl, dn, bz);
      chk_burst("post_rst", en, vl, dn, bz, 16'h0006, 16'h000C, 16'h0008, 16'h000E);

`ifdef BANK_ACCESS_CTRL_COLL_STALL_EN
      // Write to the first burst address in the first issue cycle.
      rd_q.push_back(10'h010); rd_q.push_back(10'h011);
      vl_q.push_back(0); vl_q.push_back(1);
      rd_start = 1; rd_base = 10'h010; rd_len = 11'd2;
      @(negedge clk);
      tick();
      rd_start = 0;
      wri_req = 1; wri_addr = 10'h010;
      wr_q.push_back({3'b001, 10'h010, 2'b00});
      @(negedge clk);
      chk("coll_rd_en_held", {31'd0, rd_en}, 32'd0);
      tick();
      wri_req = 0;
      @(negedge clk);
      chk("coll_rd_en_next", {31'd0, rd_en}, 32'd1);
      tick();
      repeat (4) tick();
`endif

      repeat (4) tick();
      chk("wr_q_empty", wr_q.size(), 32'd0);
      chk("rd_q_empty", rd_q.size(), 32'd0);
      chk("vl_q_empty", vl_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
